// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART receive path.
//             - uart_state_e : receiver FSM state encoding
//             - clks_per_bit : rounded clock-to-baud divider
//             - DATA_BITS    : payload bits per frame (8N1)
//             - SYNC_STAGES  : depth of the line synchroniser
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

    // Divider rounded to the nearest integer so the bit period error stays
    // within half a clock.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_if
//  Purpose  : Byte stream from the UART receiver to its consumer, plus the
//             receiver's status pulses.
//  Signals  : data[7:0]  received byte, stable while valid is high
//             valid      byte available
//             ready      consumer accepts the byte (transfer = valid & ready)
//             frame_err  one-cycle pulse, stop bit sampled low
//             overrun    one-cycle pulse, completed byte dropped (buffer full)
//             busy       receiver FSM is not idle
//  Modports : master = receiver side, slave = consumer side
//  Revision : 1.0  initial release
// ============================================================================
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output data, valid, frame_err, overrun, busy,
        input  ready
    );

    modport slave (
        input  data, valid, frame_err, overrun, busy,
        output ready
    );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Generic 1-bit two-flop synchroniser for an asynchronous input.
//  Ports    : clk    destination clock
//             rst_n  asynchronous active-low reset
//             d_i    asynchronous input
//             q_o    synchronised output, lags d_i by two clocks
//  Params   : RESET_VAL  value both flops take in reset (idle level of d_i)
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff
    import uart_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with a one-byte output buffer, framing-error
//             and overrun pulses.
//  Ports    : clk      core clock
//             reset_n  asynchronous active-low reset
//             rx       raw serial line, asynchronous, idle high
//             bus      uart_rx_if.master: data/valid/ready stream + status
//  Params   : CLK_FREQ  core clock in Hz
//             BAUD      line rate in bit/s
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(DATA_BITS);

    localparam logic [CW-1:0] c_cnt_last  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_half_last = CW'(HALF - 1);
    localparam logic [BW-1:0] c_bit_last  = BW'(DATA_BITS - 1);

    // Below four clocks per bit the half-bit point collapses onto the edges.
    if (CLKS_PER_BIT < 4) begin : g_bad_divider
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    // ------------------------------------------------------------------
    // Line synchroniser (resets to the idle level so no false start bit)
    // ------------------------------------------------------------------
    logic rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    uart_state_e          state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 done_q;      // good stop bit seen last edge
    logic                 frame_err_q;
    logic                 busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    // Held at zero so START begins counting from the
                    // detection edge.
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt_q == c_half_last) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (rx_s) begin
                            // Line is back high at mid start bit: glitch.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (cnt_q == c_cnt_last) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == c_bit_last) begin
                            state_q <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (cnt_q == c_cnt_last) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end
                end

                WAIT_HIGH: begin
                    // Absorbs a break: no new start is looked for until the
                    // line has returned high.
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // One-byte output buffer
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 overrun_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (done_q) begin
                // A transfer in the same cycle frees the buffer for the
                // new byte, so valid simply stays high.
                if (!valid_q || bus.ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking testbench for uart_rx at 1 MHz / 100 kbaud.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int CPB      = (CLK_FREQ + BAUD / 2) / BAUD;   // 10
    localparam int HALF     = CPB / 2;                        // 5
    // Pin start edge to valid, in clocks.
    localparam int LAT      = 2 + HALF + 9 * CPB + 1;         // 98

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rx      = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Observation: edge counter and a negedge monitor of the byte stream
    // ------------------------------------------------------------------
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned rise_q[$];          // edge index at which valid rose
    logic [7:0]  xfer_q[$];          // bytes transferred (valid & ready)
    int          vcycles       = 0;
    int          vfalls        = 0;
    int          ferrs         = 0;
    int          ovrs          = 0;
    int          stab_errs     = 0;
    int unsigned last_ferr_cyc = 0;
    logic        vprev         = 1'b0;
    logic        xprev         = 1'b0;
    logic [7:0]  dprev         = 8'h00;

    always @(negedge clk) begin
        if (bus.valid && !vprev) rise_q.push_back(cyc);
        if (!bus.valid && vprev) vfalls <= vfalls + 1;
        if (bus.valid) vcycles <= vcycles + 1;
        if (bus.valid && bus.ready) xfer_q.push_back(bus.data);
        if (bus.frame_err) begin
            ferrs         <= ferrs + 1;
            last_ferr_cyc <= cyc;
        end
        if (bus.overrun) ovrs <= ovrs + 1;
        // A pending, untransferred byte must not change.
        if (vprev && bus.valid && !xprev && bus.data !== dprev)
            stab_errs <= stab_errs + 1;
        vprev <= bus.valid;
        xprev <= bus.valid && bus.ready;
        dprev <= bus.data;
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; 'start' is the last edge before the pin falls.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              output int unsigned start);
        start = cyc;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
    endtask

    // Reference expectation for one good frame: exactly one valid rise,
    // LAT clocks after the first edge that sees the low pin, carrying b.
    task automatic expect_rx(input string tag, input int unsigned start,
                             input logic [7:0] b, input int ri, input int xi);
        check({tag, "_rise_cnt"}, rise_q.size(), ri + 1);
        if (rise_q.size() > ri) check({tag, "_latency"}, rise_q[ri] - start, LAT + 1);
        check({tag, "_xfer_cnt"}, xfer_q.size(), xi + 1);
        if (xfer_q.size() > xi) check({tag, "_data"}, xfer_q[xi], b);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int unsigned s;
    int          ri, xi, f0, o0, v0, vf0;
    logic [7:0]  rb;

    initial begin
        bus.ready = 1'b1;

        // Reset values
        tick(3);
        check("rst_data",      bus.data,      8'h00);
        check("rst_valid",     bus.valid,     1'b0);
        check("rst_frame_err", bus.frame_err, 1'b0);
        check("rst_overrun",   bus.overrun,   1'b0);
        check("rst_busy",      bus.busy,      1'b0);
        reset_n = 1'b1;
        tick(2);

        // Good frame with ready tied high
        ri = rise_q.size(); xi = xfer_q.size(); f0 = ferrs; o0 = ovrs; v0 = vcycles;
        send_frame(8'h55, 1'b1, s);
        tick(2);
        expect_rx("good55", s, 8'h55, ri, xi);
        check("good55_valid_width", vcycles - v0, 1);
        check("good55_ferr", ferrs - f0, 0);
        check("good55_ovr",  ovrs - o0, 0);
        check("good55_busy", bus.busy, 1'b0);

        // Random bytes with random gaps (gap 0 = back-to-back frames)
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            ri = rise_q.size(); xi = xfer_q.size();
            send_frame(rb, 1'b1, s);
            expect_rx($sformatf("rand%0d", k), s, rb, ri, xi);
            tick($urandom_range(0, 12));
        end

        // Backpressure and overrun
        bus.ready = 1'b0;
        ri = rise_q.size(); xi = xfer_q.size(); o0 = ovrs;
        send_frame(8'hA3, 1'b1, s);
        check("bp_valid",  bus.valid, 1'b1);
        check("bp_data",   bus.data,  8'hA3);
        send_frame(8'h3C, 1'b1, s);
        check("ovr_count", ovrs - o0, 1);
        check("ovr_data",  bus.data,  8'hA3);
        check("ovr_valid", bus.valid, 1'b1);
        check("ovr_rises", rise_q.size(), ri + 1);
        tick(3);
        bus.ready = 1'b1;
        tick(1);
        check("drain_valid", bus.valid, 1'b0);
        check("drain_cnt",   xfer_q.size(), xi + 1);
        if (xfer_q.size() > xi) check("drain_data", xfer_q[xi], 8'hA3);

        // Transfer coinciding with completion of the next byte
        bus.ready = 1'b0;
        xi = xfer_q.size(); o0 = ovrs;
        send_frame(8'h11, 1'b1, s);
        vf0 = vfalls; ri = rise_q.size();
        fork
            send_frame(8'h22, 1'b1, s);
            begin
                // ready high only in the cycle whose closing edge delivers 0x22
                tick(LAT);
                bus.ready = 1'b1;
                tick(1);
                bus.ready = 1'b0;
            end
        join
        check("sim_xfer_cnt", xfer_q.size(), xi + 1);
        if (xfer_q.size() > xi) check("sim_xfer_data", xfer_q[xi], 8'h11);
        check("sim_data",   bus.data,  8'h22);
        check("sim_valid",  bus.valid, 1'b1);
        check("sim_no_ovr", ovrs - o0, 0);
        check("sim_no_drop", vfalls - vf0, 0);
        check("sim_no_rise", rise_q.size(), ri);
        bus.ready = 1'b1;
        tick(1);
        check("sim_drain_valid", bus.valid, 1'b0);
        if (xfer_q.size() > xi + 1) check("sim_drain_data", xfer_q[xi + 1], 8'h22);
        else check("sim_drain_cnt", xfer_q.size(), xi + 2);

        // Glitch rejection
        ri = rise_q.size(); f0 = ferrs;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        check("glitch_busy_hi", bus.busy, 1'b1);
        tick(20);
        check("glitch_busy_lo", bus.busy, 1'b0);
        check("glitch_no_rise", rise_q.size(), ri);
        check("glitch_no_ferr", ferrs - f0, 0);

        // Framing error followed by a break
        ri = rise_q.size(); f0 = ferrs;
        send_frame(8'hF0, 1'b0, s);
        check("ferr_count", ferrs - f0, 1);
        check("ferr_time",  last_ferr_cyc - s, LAT);
        tick(30 * CPB);
        check("brk_busy",     bus.busy, 1'b1);
        check("brk_one_ferr", ferrs - f0, 1);
        check("brk_no_rise",  rise_q.size(), ri);
        rx = 1'b1;
        tick(5);
        check("brk_idle", bus.busy, 1'b0);
        ri = rise_q.size(); xi = xfer_q.size();
        send_frame(8'h0F, 1'b1, s);
        tick(1);
        expect_rx("after_brk", s, 8'h0F, ri, xi);

        // Reset mid-frame with a byte pending
        bus.ready = 1'b0;
        send_frame(8'h99, 1'b1, s);
        check("pend_valid", bus.valid, 1'b1);
        fork
            send_frame(8'h81, 1'b1, s);
            begin
                tick(5 * CPB + 5);   // inside bit 4
                reset_n = 1'b0;
                #1;
                check("mrst_valid", bus.valid, 1'b0);
                check("mrst_data",  bus.data,  8'h00);
                check("mrst_busy",  bus.busy,  1'b0);
                check("mrst_ovr",   bus.overrun, 1'b0);
            end
        join
        reset_n = 1'b1;
        tick(3);
        bus.ready = 1'b1;
        ri = rise_q.size(); xi = xfer_q.size();
        send_frame(8'h7E, 1'b1, s);
        tick(1);
        expect_rx("post_rst", s, 8'h7E, ri, xi);

        check("data_stable", stab_errs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver that sits directly upstream of the uwuifier text core.
- Converts the asynchronous serial line into bytes and presents them on a valid/ready byte stream.
- Holds one byte of buffering, and reports framing errors and overruns.
- Runs entirely on the core clock (25 MHz in the board build).

Parameters:
- CLK_FREQ, 25000000, core clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, derived as (CLK_FREQ + BAUD/2) / BAUD, i.e. 217 at the defaults. Elaboration must fail if it is below 4.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  reset; asynchronous assert, active-low.
- rx  in  1  raw serial line; asynchronous to clk, idle high.
- data  out  8  received byte; stable while valid is high.
- valid  out  1  byte available.
- ready  in  1  consumer accepts the byte; a transfer happens when valid and ready are both high.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a completed byte was dropped because the buffer was full.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: data=0, valid=0, frame_err=0, overrun=0, busy=0. The synchroniser flops reset to 1 (line idle), and the FSM resets to IDLE.
- Reset is asynchronous active-low. Asserting it mid-frame aborts the frame and empties the buffer.
- Synchronisation: rx passes through a 2-flop synchroniser to produce rx_s, which lags the pin by 2 clocks. Nothing else reads rx directly.
- Bit counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state entry. HALF = CLKS_PER_BIT/2, truncated.
- Let t0 be the first clk edge at which rx_s==0 while the FSM is in IDLE.
- IDLE: when rx_s==0, go to START and clear the counter.
- START: sample rx_s at t0+HALF.
  - If rx_s==0, go to DATA.
  - If rx_s==1, the event is a glitch: return to IDLE with no pulse.
- DATA: bit k (k=0..7, LSB first) is sampled at t0+HALF+(k+1)*CLKS_PER_BIT into a shift register. After bit 7, go to STOP.
- STOP: sample at t0+HALF+9*CLKS_PER_BIT.
  - If rx_s==1, the byte is good and the FSM returns to IDLE.
  - If rx_s==0, pulse frame_err, discard the byte and go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This covers a break condition: a line held low produces exactly one frame_err and no spurious frames.
- Delivery of a good byte: data is loaded and valid asserts on the clk edge after the stop sample. Latency from the start edge at the pin to valid is 2 + HALF + 9*CLKS_PER_BIT + 1 clocks.
- Output buffer:
  - valid stays high until a transfer occurs; valid deasserts on the edge after the transfer.
  - data must not change while valid is high and no transfer has occurred.
- Simultaneous events at byte completion:
  - Good byte completes, valid=1 and ready=1 in the same cycle: the old byte transfers, the new byte loads, and valid stays 1. No overrun.
  - Good byte completes, valid=1 and ready=0: the new byte is dropped, overrun pulses, and the old data is kept.
- Back-to-back frames: a start edge detected in the cycle IDLE is re-entered after STOP must be accepted, so there is no dead time between frames.
- Errors are pulses, not sticky flags. Counting them is the consumer's job.

Decomposition:
- Package uart_pkg holds:
  - the state enum {IDLE, START, DATA, STOP, WAIT_HIGH};
  - a function clks_per_bit(clk_freq, baud);
  - the constants DATA_BITS=8 and SYNC_STAGES=2.
- One sub-module: sync_2ff, a generic 1-bit two-flop synchroniser with parameterised reset value. The uart_tx side reuses it for its own inputs.

Test Plan (CLK_FREQ=1000000, BAUD=100000, so CLKS_PER_BIT=10, HALF=5, latency 98 clocks):
- Good frame, ready tied 1: send 0x55 -> valid pulses for exactly 1 cycle at pin-edge+98, data=0x55, no error pulses.
- Backpressure and overrun: ready=0, send 0xA3 then 0x3C back-to-back -> first frame gives valid=1 with data=0xA3 held; second frame gives an overrun pulse and data stays 0xA3. Raising ready -> one transfer of 0xA3, then valid=0.
- Simultaneous transfer and completion: byte 0x11 is pending; assert ready exactly in 0x22's completion cycle -> 0x11 transfers, data=0x22, valid never drops, no overrun.
- Glitch rejection: 3-clock low pulse on rx -> FSM returns to IDLE from START, no valid, no frame_err.
- Framing error and break: send 0xF0 with the stop bit low, then hold rx low for 30 bit-times -> exactly one frame_err, no valid, busy high until rx rises. The next 0x0F frame is then received correctly.
- Reset mid-frame: drop reset_n during bit 4 of 0x81 while a previous byte is pending -> outputs go to reset values immediately. After release, a fresh 0x7E is received with correct timing.
